// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-side signals of the shared port.
// slave is the arbiter's view, master is the requester/memory view.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_flush;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic                d_req;
   logic                d_we;
   logic [DATA_W/8-1:0] d_be;
   logic [ADDR_W-1:0]   d_addr;
   logic [DATA_W-1:0]   d_wdata;
   logic                d_gnt;
   logic                d_rvalid;
   logic [DATA_W-1:0]   d_rdata;

   logic                mem_en;
   logic                mem_we;
   logic [DATA_W/8-1:0] mem_be;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W-1:0]   mem_rdata;
   logic                busy;

   modport slave (
      input  if_req, if_addr, if_flush,
      input  d_req, d_we, d_be, d_addr, d_wdata,
      input  mem_rdata,
      output if_gnt, if_rvalid, if_rdata,
      output d_gnt, d_rvalid, d_rdata,
      output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      output busy
   );

   modport master (
      output if_req, if_addr, if_flush,
      output d_req, d_we, d_be, d_addr, d_wdata,
      output mem_rdata,
      input  if_gnt, if_rvalid, if_rdata,
      input  d_gnt, d_rvalid, d_rdata,
      input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      input  busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and load/store,
// tracking a single outstanding read through a fixed latency.
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      O_NONE,
      O_IF,
      O_D
   } owner_t;

   owner_t     owner;
   logic [2:0] cnt;
   logic       flush;
   logic [3:0] scnt;

   logic resp;
   logic free;
   logic starved;
   logic fwin;
   logic dwin;
   logic rd_gnt;
   logic ivld;
   logic dvld;

   always_comb begin
      resp    = (owner != O_NONE) && (cnt == 3'd1);
      free    = (owner == O_NONE) || resp;
      starved = scnt == 4'(STARVE_MAX);
      fwin    = rst && free && bus.if_req
                && (!bus.d_req || starved);
      dwin    = rst && free && bus.d_req
                && !(bus.if_req && starved);
      rd_gnt  = fwin || (dwin && !bus.d_we);
      // a flush raised in the response cycle itself still kills it
      ivld    = rst && resp && (owner == O_IF)
                && !flush && !bus.if_flush;
      dvld    = rst && resp && (owner == O_D);
   end

   assign bus.if_gnt    = fwin;
   assign bus.d_gnt     = dwin;
   assign bus.busy      = rst && (owner != O_NONE) && !resp;
   assign bus.if_rvalid = ivld;
   assign bus.d_rvalid  = dvld;
   assign bus.if_rdata  = ivld ? bus.mem_rdata : '0;
   assign bus.d_rdata   = dvld ? bus.mem_rdata : '0;

   assign bus.mem_en    = fwin || dwin;
   assign bus.mem_we    = dwin && bus.d_we;
   assign bus.mem_be    = dwin ? bus.d_be : '0;
   assign bus.mem_wdata = dwin ? bus.d_wdata : '0;
   assign bus.mem_addr  = fwin ? bus.if_addr
                        : dwin ? bus.d_addr : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         owner <= O_NONE;
         cnt   <= '0;
         flush <= 1'b0;
         scnt  <= '0;
      end else begin
         if (rd_gnt) begin
            owner <= fwin ? O_IF : O_D;
            cnt   <= 3'(MEM_LAT);
            flush <= 1'b0;
         end else if (resp) begin
            owner <= O_NONE;
            cnt   <= '0;
            flush <= 1'b0;
         end else begin
            if (cnt != 3'd0)
               cnt <= cnt - 3'd1;
            if (owner == O_IF && bus.if_flush)
               flush <= 1'b1;
         end
         if (!bus.if_req || fwin)
            scnt <= '0;
         else if (dwin && !starved)
            scnt <= scnt + 4'd1;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: three arbiters (MEM_LAT 1,2,3) fed identical stimulus,
// each compared every cycle against a timestamp-based reference model.
module tb_mem_arbiter;
   localparam int   STARVE = 4;
   localparam logic F = 1'b0;
   localparam logic T = 1'b1;
   localparam logic [31:0] Z = 32'h0;

   typedef struct packed {
      logic        rst;
      logic        if_req;
      logic [31:0] if_addr;
      logic        if_flush;
      logic        d_req;
      logic        d_we;
      logic [3:0]  d_be;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic [31:0] mem_rdata;
   } in_t;

   typedef struct packed {
      logic        if_gnt;
      logic        if_rvalid;
      logic [31:0] if_rdata;
      logic        d_gnt;
      logic        d_rvalid;
      logic [31:0] d_rdata;
      logic        mem_en;
      logic        mem_we;
      logic [3:0]  mem_be;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic        busy;
   } out_t;

   typedef struct {
      bit pend;
      int due;
      int issue;
      bit who_if;
      bit flushed;
      int starve;
   } mst_t;

   typedef struct {
      in_t  i;
      out_t x;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   in_t  cur;
   out_t obs [3];
   mst_t st  [3];
   int   t;
   int   ntot = 0;
   int   npass = 0;

   for (genvar k = 0; k < 3; k++) begin : g
      mem_arbiter_if b ();
      assign b.if_req    = cur.if_req;
      assign b.if_addr   = cur.if_addr;
      assign b.if_flush  = cur.if_flush;
      assign b.d_req     = cur.d_req;
      assign b.d_we      = cur.d_we;
      assign b.d_be      = cur.d_be;
      assign b.d_addr    = cur.d_addr;
      assign b.d_wdata   = cur.d_wdata;
      assign b.mem_rdata = cur.mem_rdata;
      assign obs[k] = {b.if_gnt, b.if_rvalid, b.if_rdata,
                       b.d_gnt, b.d_rvalid, b.d_rdata,
                       b.mem_en, b.mem_we, b.mem_be,
                       b.mem_addr, b.mem_wdata, b.busy};
      mem_arbiter #(
         .ADDR_W(32), .DATA_W(32),
         .MEM_LAT(k + 1), .STARVE_MAX(STARVE)
      ) dut (
         .clk(clk),
         .rst(cur.rst),
         .bus(b)
      );
   end

   function automatic in_t mk_in(
      logic rst, logic ifr, logic [31:0] ia, logic fl,
      logic dr, logic we, logic [3:0] be, logic [31:0] da,
      logic [31:0] wd, logic [31:0] rd);
      return {rst, ifr, ia, fl, dr, we, be, da, wd, rd};
   endfunction

   function automatic out_t mk_out(
      logic ig, logic iv, logic [31:0] ird,
      logic dg, logic dv, logic [31:0] drd,
      logic en, logic we, logic [3:0] be,
      logic [31:0] addr, logic [31:0] wd, logic bsy);
      return {ig, iv, ird, dg, dv, drd, en, we, be,
              addr, wd, bsy};
   endfunction

   function automatic in_t idle(logic [31:0] rd);
      return mk_in(T, F, Z, F, F, F, 4'h0, Z, Z, rd);
   endfunction

   // One pending read remembered by issue and due timestamps.
   function automatic void model(
      input in_t i, input int lat, input int now,
      input mst_t s, output mst_t ns, output out_t o);
      bit resp, free, fw, dw, sup;
      o  = '0;
      ns = s;
      if (!i.rst) begin
         ns = '{default: 0};
         return;
      end
      resp = s.pend && (s.due == now);
      free = !s.pend || resp;
      sup  = s.flushed || i.if_flush;
      if (resp && s.who_if && !sup) begin
         o.if_rvalid = 1'b1;
         o.if_rdata  = i.mem_rdata;
      end
      if (resp && !s.who_if) begin
         o.d_rvalid = 1'b1;
         o.d_rdata  = i.mem_rdata;
      end
      o.busy = s.pend && !resp;
      fw = free && i.if_req && (!i.d_req || s.starve == STARVE);
      dw = free && i.d_req && !fw;
      o.if_gnt = fw;
      o.d_gnt  = dw;
      o.mem_en = fw || dw;
      if (fw) o.mem_addr = i.if_addr;
      if (dw) begin
         o.mem_addr  = i.d_addr;
         o.mem_we    = i.d_we;
         o.mem_be    = i.d_be;
         o.mem_wdata = i.d_wdata;
      end
      if (s.pend && !resp && s.who_if && i.if_flush && now > s.issue)
         ns.flushed = 1'b1;
      if (resp) ns.pend = 1'b0;
      if (fw || (dw && !i.d_we)) begin
         ns.pend    = 1'b1;
         ns.issue   = now;
         ns.due     = now + lat;
         ns.who_if  = fw;
         ns.flushed = 1'b0;
      end
      if (!i.if_req || fw)
         ns.starve = 0;
      else if (dw && s.starve < STARVE)
         ns.starve = s.starve + 1;
   endfunction

   task automatic chk(input string nm,
                      input logic [199:0] got,
                      input logic [199:0] want);
      ntot++;
      if (got === want) npass++;
      else $display("FAIL %s got=%0h want=%0h", nm, got, want);
   endtask

   task automatic apply(input in_t i);
      mst_t ns;
      out_t o;
      cur = i;
      #2;
      for (int k = 0; k < 3; k++) begin
         model(i, k + 1, t, st[k], ns, o);
         chk($sformatf("model_lat%0d_t%0d", k + 1, t),
             200'(obs[k]), 200'(o));
         st[k] = ns;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      t++;
   endtask

   initial begin
      vec_t  tv [$];
      in_t   ri;
      string exp_ord;
      byte   got_c;
      byte   exp_c;

      t = 0;
      for (int k = 0; k < 3; k++) st[k] = '{default: 0};
      cur = mk_in(F, F, Z, F, F, F, 4'h0, Z, Z, Z);

      // expectations below are for the MEM_LAT=2 instance
      for (int n = 0; n < 3; n++)
         tv.push_back('{mk_in(F, T, 32'h100, F, T, F, 4'hf,
                              32'h300, Z, Z),
                        mk_out(F, F, Z, F, F, Z, F, F, 4'h0,
                               Z, Z, F)});
      tv.push_back('{mk_in(T, T, 32'h100, F, T, F, 4'hf,
                           32'h300, Z, Z),
                     mk_out(F, F, Z, T, F, Z, T, F, 4'hf,
                            32'h300, Z, F)});
      tv.push_back('{idle(Z),
                     mk_out(F, F, Z, F, F, Z, F, F, 4'h0,
                            Z, Z, T)});
      tv.push_back('{idle(32'h11112222),
                     mk_out(F, F, Z, F, T, 32'h11112222, F, F,
                            4'h0, Z, Z, F)});
      tv.push_back('{mk_in(T, T, 32'h100, F, F, F, 4'h0, Z, Z, Z),
                     mk_out(T, F, Z, F, F, Z, T, F, 4'h0,
                            32'h100, Z, F)});
      tv.push_back('{idle(Z),
                     mk_out(F, F, Z, F, F, Z, F, F, 4'h0,
                            Z, Z, T)});
      tv.push_back('{idle(32'h13),
                     mk_out(F, T, 32'h13, F, F, Z, F, F, 4'h0,
                            Z, Z, F)});
      tv.push_back('{mk_in(T, T, 32'h104, F, T, T, 4'h3,
                           32'h200, 32'hDEADBEEF, Z),
                     mk_out(F, F, Z, T, F, Z, T, T, 4'h3,
                            32'h200, 32'hDEADBEEF, F)});
      tv.push_back('{mk_in(T, T, 32'h104, F, F, F, 4'h0, Z, Z, Z),
                     mk_out(T, F, Z, F, F, Z, T, F, 4'h0,
                            32'h104, Z, F)});
      tv.push_back('{mk_in(T, F, Z, T, F, F, 4'h0, Z, Z, Z),
                     mk_out(F, F, Z, F, F, Z, F, F, 4'h0,
                            Z, Z, T)});
      tv.push_back('{mk_in(T, F, Z, F, T, F, 4'hf, 32'h400,
                           Z, 32'hAAAA5555),
                     mk_out(F, F, Z, T, F, Z, T, F, 4'hf,
                            32'h400, Z, F)});
      tv.push_back('{idle(32'h99),
                     mk_out(F, F, Z, F, F, Z, F, F, 4'h0,
                            Z, Z, T)});
      tv.push_back('{idle(32'h12345678),
                     mk_out(F, F, Z, F, T, 32'h12345678, F, F,
                            4'h0, Z, Z, F)});
      tv.push_back('{mk_in(T, T, 32'h108, F, F, F, 4'h0, Z, Z, Z),
                     mk_out(T, F, Z, F, F, Z, T, F, 4'h0,
                            32'h108, Z, F)});
      tv.push_back('{idle(Z),
                     mk_out(F, F, Z, F, F, Z, F, F, 4'h0,
                            Z, Z, T)});
      tv.push_back('{mk_in(T, F, Z, T, F, F, 4'h0, Z, Z, 32'h77),
                     mk_out(F, F, Z, F, F, Z, F, F, 4'h0,
                            Z, Z, F)});
      tv.push_back('{mk_in(T, T, 32'h10c, T, F, F, 4'h0, Z, Z, Z),
                     mk_out(T, F, Z, F, F, Z, T, F, 4'h0,
                            32'h10c, Z, F)});
      tv.push_back('{idle(Z),
                     mk_out(F, F, Z, F, F, Z, F, F, 4'h0,
                            Z, Z, T)});
      tv.push_back('{idle(32'h55),
                     mk_out(F, T, 32'h55, F, F, Z, F, F, 4'h0,
                            Z, Z, F)});

      @(negedge clk);
      foreach (tv[n]) begin
         apply(tv[n].i);
         chk($sformatf("vec%0d_lat2", n), 200'(obs[1]),
             200'(tv[n].x));
         tick();
      end

      // starvation: both requesters held, MEM_LAT=1 instance
      apply(mk_in(F, F, Z, F, F, F, 4'h0, Z, Z, Z));
      tick();
      exp_ord = "DDDDIDDDDI";
      for (int n = 0; n < 10; n++) begin
         apply(mk_in(T, T, 32'h180, F, T, F, 4'hf,
                     32'h380, Z, 32'(n)));
         got_c = obs[0].d_gnt ? 8'h44 : obs[0].if_gnt ? 8'h49 : 8'h2d;
         exp_c = exp_ord[n];
         chk($sformatf("starve_order%0d", n), 200'(got_c),
             200'(exp_c));
         tick();
      end

      // reset in the middle of a MEM_LAT=3 load
      apply(mk_in(F, F, Z, F, F, F, 4'h0, Z, Z, Z));
      tick();
      apply(mk_in(T, F, Z, F, T, F, 4'hf, 32'h500, Z, Z));
      chk("midrst_c0_gnt", 200'(obs[2].d_gnt), 200'(1));
      tick();
      apply(mk_in(F, F, Z, F, F, F, 4'h0, Z, Z, Z));
      chk("midrst_c1_busy", 200'(obs[2].busy), 200'(0));
      tick();
      for (int n = 2; n <= 5; n++) begin
         apply(idle(32'hCAFE0000 + 32'(n)));
         chk($sformatf("midrst_c%0d_rvalid", n),
             200'(obs[2].d_rvalid), 200'(0));
         tick();
      end
      apply(mk_in(T, F, Z, F, T, F, 4'hf, 32'h504, Z, Z));
      chk("midrst_regrant", 200'(obs[2].d_gnt), 200'(1));
      tick();

      for (int n = 0; n < 500; n++) begin
         ri.rst       = $urandom_range(0, 49) != 0;
         ri.if_req    = $urandom_range(0, 9) < 6;
         ri.if_addr   = $urandom;
         ri.if_flush  = $urandom_range(0, 4) == 0;
         ri.d_req     = $urandom_range(0, 9) < 6;
         ri.d_we      = $urandom_range(0, 2) == 0;
         ri.d_be      = 4'($urandom);
         ri.d_addr    = $urandom;
         ri.d_wdata   = $urandom;
         ri.mem_rdata = $urandom;
         apply(ri);
         tick();
      end

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
